// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync header then payload, MSB first, on a registered 1-bit line.
// Optional even-parity bit after the payload is enabled by defining SEQ_TX_PARITY_EN.
module seq_frame_tx #(
  parameter int                DATA_W   = 8,
  parameter int                SYNC_W   = 4,
  parameter logic [SYNC_W-1:0] SYNC     = 4'b1001,
  parameter int                GAP_BITS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              dout_o,
  output logic              dout_en_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int FW    = SYNC_W + DATA_W;
  localparam int MAX_A = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int MAX_C = (MAX_A > GAP_BITS) ? MAX_A : GAP_BITS;
  localparam int CNT_W = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] SYNC_LD = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LD = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SYNC = 3'd1,
    S_DATA = 3'd2,
`ifdef SEQ_TX_PARITY_EN
    S_PAR  = 3'd4,
`endif
    S_GAP  = 3'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic              dout_q, dout_d;
  logic              dout_en_q, dout_en_d;
  logic              frame_done_q, frame_done_d;
`ifdef SEQ_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  // State register; the serial outputs are registered alongside so they line up with state_q
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      frame_q      <= '0;
      dout_q       <= 1'b0;
      dout_en_q    <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      frame_q      <= frame_d;
      dout_q       <= dout_d;
      dout_en_q    <= dout_en_d;
      frame_done_q <= frame_done_d;
`ifdef SEQ_TX_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  // Next-state logic; header and payload share one left-shifting register
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
`ifdef SEQ_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (tx_valid_i) begin
          state_d = S_SYNC;
          cnt_d   = SYNC_LD;
          frame_d = {SYNC, tx_data_i};
`ifdef SEQ_TX_PARITY_EN
          par_d   = ^tx_data_i;
`endif
        end
      end
      S_SYNC: begin
        frame_d = frame_q << 1;
        if (cnt_q == '0) begin
          state_d = S_DATA;
          cnt_d   = DATA_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DATA: begin
        frame_d = frame_q << 1;
        if (cnt_q == '0) begin
`ifdef SEQ_TX_PARITY_EN
          state_d = S_PAR;
          cnt_d   = '0;
`else
          state_d = (GAP_BITS == 0) ? S_IDLE : S_GAP;
          cnt_d   = GAP_LD;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef SEQ_TX_PARITY_EN
      S_PAR: begin
        state_d = (GAP_BITS == 0) ? S_IDLE : S_GAP;
        cnt_d   = GAP_LD;
      end
`endif
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state, so the registered bit appears in the state's own cycle
  always_comb begin
    dout_d       = 1'b0;
    dout_en_d    = 1'b0;
    frame_done_d = 1'b0;
    case (state_d)
      S_SYNC: begin
        dout_d    = frame_d[FW-1];
        dout_en_d = 1'b1;
      end
      S_DATA: begin
        dout_d    = frame_d[FW-1];
        dout_en_d = 1'b1;
`ifndef SEQ_TX_PARITY_EN
        frame_done_d = (cnt_d == '0);
`endif
      end
`ifdef SEQ_TX_PARITY_EN
      S_PAR: begin
        dout_d       = par_d;
        dout_en_d    = 1'b1;
        frame_done_d = 1'b1;
      end
`endif
      default: begin
        dout_d       = 1'b0;
        dout_en_d    = 1'b0;
        frame_done_d = 1'b0;
      end
    endcase
  end

  assign tx_ready_o   = (state_q == S_IDLE) && !reset;
  assign busy_o       = (state_q != S_IDLE) && !reset;
  assign dout_o       = dout_q;
  assign dout_en_o    = dout_en_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench for seq_frame_tx (default parameters); follows SEQ_TX_PARITY_EN if defined.
module tb_seq_frame_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, dout, dout_en, busy, frame_done;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  localparam int G = 2;
`ifdef SEQ_TX_PARITY_EN
  localparam int FL = 13;
  localparam logic [15:0] F_A5 = 16'h134A;
  localparam logic [15:0] F_07 = 16'h120F;
  localparam logic [15:0] F_3C = 16'h1278;
  localparam logic [15:0] F_C3 = 16'h1386;
  localparam logic [15:0] F_81 = 16'h1302;
  localparam logic [15:0] F_00 = 16'h1200;
`else
  localparam int FL = 12;
  localparam logic [15:0] F_A5 = 16'h09A5;
  localparam logic [15:0] F_07 = 16'h0907;
  localparam logic [15:0] F_3C = 16'h093C;
  localparam logic [15:0] F_C3 = 16'h09C3;
  localparam logic [15:0] F_81 = 16'h0981;
  localparam logic [15:0] F_00 = 16'h0900;
`endif

  seq_frame_tx dut (
    .clk          (clk),
    .reset        (reset),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .dout_o       (dout),
    .dout_en_o    (dout_en),
    .busy_o       (busy),
    .frame_done_o (frame_done)
  );

  always #5 clk = ~clk;

  // Reference 1001 detector on the raw serial line, sampled mid-cycle
  logic [3:0] det_sh  = 4'b0000;
  int         det_cnt = 0;
  int         det_pos = 0;
  int         en_run  = 0;
  always @(negedge clk) begin
    det_sh <= {det_sh[2:0], dout};
    en_run <= dout_en ? en_run + 1 : 0;
    if ({det_sh[2:0], dout} == 4'b1001) begin
      det_cnt <= det_cnt + 1;
      det_pos <= dout_en ? en_run + 1 : 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  // Called in the cycle of the first frame bit; returns in the cycle after the last bit
  task automatic check_frame(input string tag, input logic [15:0] bits);
    for (int i = 0; i < FL; i++) begin
      chk($sformatf("%s_b%0d_dout", tag, i), dout, bits[FL-1-i]);
      chk($sformatf("%s_b%0d_en", tag, i), dout_en, 1'b1);
      chk($sformatf("%s_b%0d_done", tag, i), frame_done, (i == FL - 1));
      chk($sformatf("%s_b%0d_busy", tag, i), busy, 1'b1);
      tick();
    end
  endtask

  // Gap cycles then the IDLE cycle (left in IDLE)
  task automatic check_gap(input string tag);
    for (int g = 0; g < G; g++) begin
      chk($sformatf("%s_g%0d_dout", tag, g), dout, 1'b0);
      chk($sformatf("%s_g%0d_en", tag, g), dout_en, 1'b0);
      chk($sformatf("%s_g%0d_done", tag, g), frame_done, 1'b0);
      chk($sformatf("%s_g%0d_ready", tag, g), tx_ready, 1'b0);
      tick();
    end
    chk({tag, "_idle_ready"}, tx_ready, 1'b1);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_idle_en"}, dout_en, 1'b0);
  endtask

  int det_before;

  initial begin
    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst%0d_ready", i), tx_ready, 1'b0);
      chk($sformatf("rst%0d_dout", i), dout, 1'b0);
      chk($sformatf("rst%0d_en", i), dout_en, 1'b0);
      chk($sformatf("rst%0d_busy", i), busy, 1'b0);
    end
    reset = 1'b0;
    #1;
    chk("rel_ready", tx_ready, 1'b1);
    chk("rel_busy", busy, 1'b0);

    // Single frames
    send(8'hA5);
    check_frame("a5", F_A5);
    check_gap("a5");
    send(8'h07);
    check_frame("h07", F_07);
    check_gap("h07");
    send(8'hA5);
    check_frame("a5b", F_A5);
    check_gap("a5b");

    // Held valid: back-to-back frames, tx_data changed while the first is in flight
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    tick();
    tx_data = 8'hC3;
    check_frame("b2b1", F_3C);
    for (int g = 0; g <= G; g++) begin
      chk($sformatf("b2b_gap%0d_en", g), dout_en, 1'b0);
      chk($sformatf("b2b_gap%0d_dout", g), dout, 1'b0);
      if (g == G) chk("b2b_idle_ready", tx_ready, 1'b1);
      tick();
    end
    tx_valid = 1'b0;
    check_frame("b2b2", F_C3);
    check_gap("b2b2");

    // Reset during payload bit 3, then a clean frame
    send(8'h3C);
    for (int i = 0; i < 7; i++) tick();
    chk("mid_dout", dout, 1'b1);
    chk("mid_en", dout_en, 1'b1);
    reset = 1'b1;
    tick();
    chk("abort_dout", dout, 1'b0);
    chk("abort_en", dout_en, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", frame_done, 1'b0);
    chk("abort_ready", tx_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk("abort_rel_ready", tx_ready, 1'b1);
    send(8'h81);
    check_frame("h81", F_81);
    check_gap("h81");

    // Sequence-detector loopback on all-zero payloads
    for (int f = 0; f < 3; f++) begin
      det_before = det_cnt;
      send(8'h00);
      check_frame($sformatf("z%0d", f), F_00);
      check_gap($sformatf("z%0d", f));
      chk($sformatf("z%0d_detcnt", f), det_cnt - det_before, 1);
      chk($sformatf("z%0d_detpos", f), det_pos, 4);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
